// File: rtl/dplca_node_fsm.sv
// dplca_node_fsm: D-PLCA node role controller owning local_nodeID, the node count and the wait_beacon timer.
module dplca_node_fsm #(
    parameter int ID_W               = 8,
    parameter int MIN_NODE_COUNT     = 8,
    parameter int INC_STEP           = 1,
    parameter int WAIT_BEACON_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      plca_reset,
    input  logic                      dplca_en,
    input  logic                      plca_en,
    input  logic                      coordinator_role_allowed,
    input  logic                      plca_status,
    input  logic [1:0]                rx_cmd,
    input  logic [1:0]                tx_cmd,
    input  logic                      dplca_txop_table_upd,
    input  logic                      dplca_new_age,
    input  logic [ID_W-1:0]           dplca_txop_id,
    input  logic [ID_W-1:0]           dplca_txop_node_count,
    input  logic [2*(2**ID_W)-1:0]    txop_claim_table,
    output logic [3:0]                state,
    output logic                      dplca_aging,
    output logic [ID_W-1:0]           local_nodeID,
    output logic [ID_W-1:0]           plca_node_count,
    output logic                      txop_repick
);
    localparam int D = 2 ** ID_W;
    localparam int TW = $clog2(WAIT_BEACON_CYCLES + 1);
    localparam logic [ID_W:0] MAXC_X = (ID_W+1)'(D - 1);
    localparam logic [ID_W:0] MIN_X = (ID_W+1)'(MIN_NODE_COUNT);
    localparam logic [ID_W:0] INC_X = (ID_W+1)'(INC_STEP);
    localparam logic [ID_W-1:0] MAXC_N = ID_W'(D - 1);
    localparam logic [ID_W-1:0] MIN_N = ID_W'(MIN_NODE_COUNT);
    localparam logic [ID_W-1:0] IDLE_ID = ID_W'(D - 2);
    localparam logic [TW-1:0] WB_MAX = TW'(WAIT_BEACON_CYCLES);

    typedef enum logic [3:0] {
        DISABLED            = 4'd0,
        WAIT_BEACON         = 4'd1,
        COORDINATOR         = 4'd2,
        REDUCE_NODE_COUNT   = 4'd3,
        LOOPBACK_TX         = 4'd4,
        LOOPBACK_RX         = 4'd5,
        LEARNING            = 4'd6,
        INCREASE_NODE_COUNT = 4'd7,
        FOLLOWER            = 4'd8
    } state_t;

    state_t state_q, state_d;
    logic aging_q, aging_d, repick_q, repick_d, reenter;
    logic [ID_W-1:0] id_q, id_d, count_q, count_d, max_claim, pick_free, cnt_m1;
    logic [TW-1:0] timer_q, timer_d;
    logic [D-1:0] claiming;
    logic [ID_W:0] mc2, red_x, inc_sum, inc_x;
    logic rx_bcn, tx_bcn, upd_age, timer_done;

    for (genvar g = 0; g < D; g++) begin : g_claim
        assign claiming[g] = |txop_claim_table[2*g +: 2];
    end

    always_comb begin
        max_claim = '0;
        pick_free = IDLE_ID;
        for (int i = 0; i < D; i++) if (claiming[i]) max_claim = ID_W'(i);
        for (int i = D - 1; i >= 1; i--) if (i < int'(count_q) && !claiming[i]) pick_free = ID_W'(i);
    end

    // Node-count arithmetic is widened by one bit so it clips instead of wrapping.
    assign mc2 = {1'b0, max_claim} + (ID_W+1)'(2);
    assign red_x = mc2 < MIN_X ? MIN_X : (mc2 > MAXC_X ? MAXC_X : mc2);
    assign inc_sum = {1'b0, count_q} + INC_X;
    assign inc_x = inc_sum > MAXC_X ? MAXC_X : inc_sum;
    assign cnt_m1 = count_q - 1'b1;
    assign rx_bcn = rx_cmd == 2'b00;
    assign tx_bcn = tx_cmd == 2'b00;
    assign timer_done = timer_q == WB_MAX;
    assign upd_age = dplca_txop_table_upd && dplca_new_age && !claiming[0] && !rx_bcn;

    always_comb begin
        state_d = state_q;
        reenter = 1'b0;
        if (!dplca_en || !plca_en) state_d = DISABLED;
        else case (state_q)
            DISABLED: state_d = WAIT_BEACON;
            WAIT_BEACON: state_d = plca_status ? LEARNING :
                                   timer_done ? (coordinator_role_allowed ? COORDINATOR : DISABLED) : WAIT_BEACON;
            COORDINATOR: begin
                if ((dplca_txop_table_upd && claiming[0]) || rx_bcn) state_d = LEARNING;
                else if (upd_age && claiming[cnt_m1] && count_q < MAXC_N) state_d = INCREASE_NODE_COUNT;
                else if (tx_bcn) state_d = LOOPBACK_TX;
                else if (upd_age && !claiming[cnt_m1] && count_q > MIN_N) state_d = REDUCE_NODE_COUNT;
            end
            REDUCE_NODE_COUNT, INCREASE_NODE_COUNT: state_d = dplca_new_age ? state_q : COORDINATOR;
            LOOPBACK_TX: state_d = rx_bcn ? LOOPBACK_RX : LOOPBACK_TX;
            LOOPBACK_RX: state_d = rx_bcn ? LOOPBACK_RX : COORDINATOR;
            LEARNING: state_d = (dplca_txop_table_upd && dplca_new_age && plca_status) ? FOLLOWER :
                                plca_status ? LEARNING : DISABLED;
            FOLLOWER: begin
                state_d = plca_status ? FOLLOWER : DISABLED;
                reenter = plca_status && dplca_txop_table_upd && (claiming[id_q] ||
                          (dplca_txop_id == '0 && dplca_txop_node_count <= id_q) ||
                          (dplca_new_age && id_q > max_claim));
            end
            default: state_d = DISABLED;
        endcase
    end

    // Entry actions fire on any state change and on FOLLOWER re-entry.
    always_comb begin
        aging_d = aging_q;
        id_d = id_q;
        count_d = count_q;
        repick_d = 1'b0;
        timer_d = (state_q == WAIT_BEACON && !timer_done) ? timer_q + 1'b1 : timer_q;
        if (state_d != state_q || reenter) begin
            case (state_d)
                DISABLED: begin
                    aging_d = 1'b0;
                    timer_d = '0;
                end
                WAIT_BEACON: begin
                    id_d = IDLE_ID;
                    count_d = MIN_N;
                end
                COORDINATOR: begin
                    id_d = '0;
                    aging_d = 1'b1;
                end
                LEARNING: begin
                    id_d = IDLE_ID;
                    aging_d = 1'b1;
                end
                REDUCE_NODE_COUNT: count_d = red_x[ID_W-1:0];
                INCREASE_NODE_COUNT: count_d = inc_x[ID_W-1:0];
                FOLLOWER: begin
                    id_d = pick_free;
                    repick_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge plca_reset) begin
        if (plca_reset) begin
            state_q <= DISABLED;
            aging_q <= 1'b0;
            repick_q <= 1'b0;
            id_q <= IDLE_ID;
            count_q <= MIN_N;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            aging_q <= aging_d;
            repick_q <= repick_d;
            id_q <= id_d;
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

    assign state = state_q;
    assign dplca_aging = aging_q;
    assign local_nodeID = id_q;
    assign plca_node_count = count_q;
    assign txop_repick = repick_q;
endmodule

// File: tb/tb_dplca_node_fsm.sv
// tb_dplca_node_fsm: directed role scenarios followed by randomized traffic, each edge
// checked against a rule-level reference model of the node role controller.
module tb_dplca_node_fsm;
    localparam int ID_W = 8;
    localparam int D = 256;
    localparam int MAXC = 255;
    localparam int MINC = 8;
    localparam int INC = 1;
    localparam int WBC = 4;
    localparam int S_DIS = 0, S_WB = 1, S_CRD = 2, S_RED = 3, S_LTX = 4, S_LRX = 5,
                   S_LRN = 6, S_INC = 7, S_FOL = 8;

    logic clk = 1'b0;
    logic plca_reset = 1'b0, dplca_en = 1'b0, plca_en = 1'b0, cra = 1'b0, plca_status = 1'b0;
    logic [1:0] rx_cmd = 2'b10, tx_cmd = 2'b10;
    logic upd = 1'b0, new_age = 1'b0;
    logic [ID_W-1:0] tid = '0, tcnt = '0;
    logic [2*D-1:0] claim = '0;
    logic [3:0] state;
    logic dplca_aging, txop_repick;
    logic [ID_W-1:0] local_nodeID, plca_node_count;

    int vectors = 0, miscompares = 0;
    int m_st, m_id, m_cnt, m_tmr;
    bit m_age, m_rep;

    always #5 clk = ~clk;

    dplca_node_fsm #(.ID_W(ID_W), .MIN_NODE_COUNT(MINC), .INC_STEP(INC), .WAIT_BEACON_CYCLES(WBC)) dut (
        .clk(clk), .plca_reset(plca_reset), .dplca_en(dplca_en), .plca_en(plca_en),
        .coordinator_role_allowed(cra), .plca_status(plca_status), .rx_cmd(rx_cmd), .tx_cmd(tx_cmd),
        .dplca_txop_table_upd(upd), .dplca_new_age(new_age), .dplca_txop_id(tid),
        .dplca_txop_node_count(tcnt), .txop_claim_table(claim), .state(state),
        .dplca_aging(dplca_aging), .local_nodeID(local_nodeID), .plca_node_count(plca_node_count),
        .txop_repick(txop_repick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit clm(input int i);
        return claim[2*i +: 2] != 2'b00;
    endfunction

    function automatic int max_claim();
        int r = 0;
        for (int i = 0; i < D; i++) if (clm(i)) r = i;
        return r;
    endfunction

    function automatic int pick_free();
        for (int i = 1; i < m_cnt; i++) if (!clm(i)) return i;
        return D - 2;
    endfunction

    task automatic model_reset();
        m_st = S_DIS; m_age = 0; m_rep = 0; m_id = D - 2; m_cnt = MINC; m_tmr = 0;
    endtask

    task automatic model_edge();
        int ns = m_st;
        bit re = 0;
        int mc = max_claim();
        int pf = pick_free();
        bit rxb = rx_cmd == 2'b00;
        bit txb = tx_cmd == 2'b00;
        bit ok = plca_status;
        bit ua = upd && new_age && !clm(0) && !rxb;
        bit done = m_tmr == WBC;
        m_rep = 0;
        if (!dplca_en || !plca_en) ns = S_DIS;
        else case (m_st)
            S_DIS: ns = S_WB;
            S_WB: if (ok) ns = S_LRN; else if (done) ns = cra ? S_CRD : S_DIS;
            S_CRD: begin
                if ((upd && clm(0)) || rxb) ns = S_LRN;
                else if (ua && clm(m_cnt - 1) && m_cnt < MAXC) ns = S_INC;
                else if (txb) ns = S_LTX;
                else if (ua && !clm(m_cnt - 1) && m_cnt > MINC) ns = S_RED;
            end
            S_RED, S_INC: if (!new_age) ns = S_CRD;
            S_LTX: if (rxb) ns = S_LRX;
            S_LRX: if (!rxb) ns = S_CRD;
            S_LRN: if (upd && new_age && ok) ns = S_FOL; else if (!ok) ns = S_DIS;
            S_FOL: if (!ok) ns = S_DIS;
                   else re = upd && (clm(m_id) || (tid == 0 && tcnt <= m_id) || (new_age && m_id > mc));
            default: ns = S_DIS;
        endcase
        if (m_st == S_WB && !done) m_tmr++;
        if (ns != m_st || re) case (ns)
            S_DIS: begin m_age = 0; m_tmr = 0; end
            S_WB: begin m_id = D - 2; m_cnt = MINC; end
            S_CRD: begin m_id = 0; m_age = 1; end
            S_LRN: begin m_id = D - 2; m_age = 1; end
            S_RED: m_cnt = (mc + 2 < MINC) ? MINC : (mc + 2 > MAXC ? MAXC : mc + 2);
            S_INC: m_cnt = (m_cnt + INC > MAXC) ? MAXC : m_cnt + INC;
            S_FOL: begin m_id = pf; m_rep = 1; end
            default: ;
        endcase
        m_st = ns;
    endtask

    task automatic check_model();
        chk("m_state", state, m_st);
        chk("m_aging", dplca_aging, m_age);
        chk("m_id", local_nodeID, m_id);
        chk("m_count", plca_node_count, m_cnt);
        chk("m_repick", txop_repick, m_rep);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Reset is pulsed between clock edges so its asynchronous effect is observed directly.
    task automatic do_reset();
        #1 plca_reset = 1'b1;
        #1 model_reset();
        check_model();
        chk("rst_state", state, S_DIS);
        chk("rst_id", local_nodeID, D - 2);
        #1 plca_reset = 1'b0;
    endtask

    task automatic set_claim(input int i);
        claim[2*i +: 2] = 2'b01;
    endtask

    task automatic age_pulse();
        upd = 1'b1; new_age = 1'b1;
        tick();
        upd = 1'b0; new_age = 1'b0;
    endtask

    initial begin
        dplca_en = 1'b1; plca_en = 1'b1; cra = 1'b1; plca_status = 1'b0;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("wb_hold", state, S_WB);
        end
        tick();
        chk("to_coord", state, S_CRD);
        chk("coord_id", local_nodeID, 0);
        chk("coord_aging", dplca_aging, 1);

        cra = 1'b0;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 6 || i == 12) chk("nocoord_dis", state, S_DIS);
            else chk("nocoord_wb", state, S_WB);
            chk("nocoord_id", local_nodeID, 254);
        end
        cra = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("coord2", state, S_CRD);
        chk("coord2_cnt", plca_node_count, 8);

        for (int c = 8; c < 255; c++) begin
            claim = '0; set_claim(c - 1);
            age_pulse();
            chk("inc_state", state, S_INC);
            chk("inc_cnt", plca_node_count, c + 1);
            tick();
            chk("inc_back", state, S_CRD);
        end
        claim = '0; set_claim(254);
        age_pulse();
        chk("inc_sat_state", state, S_CRD);
        chk("inc_sat_cnt", plca_node_count, 255);

        claim = '0; set_claim(12);
        age_pulse();
        chk("red12_state", state, S_RED);
        chk("red12_cnt", plca_node_count, 14);
        tick();
        claim = '0; set_claim(18);
        age_pulse();
        chk("red18_cnt", plca_node_count, 20);
        tick();
        claim = '0; set_claim(3);
        age_pulse();
        chk("red3_state", state, S_RED);
        chk("red3_floor", plca_node_count, 8);
        tick();
        chk("red_back", state, S_CRD);

        claim = '0;
        for (int i = 0; i < 4; i++) set_claim(i);
        plca_status = 1'b1; rx_cmd = 2'b00;
        tick();
        chk("learn", state, S_LRN);
        chk("learn_id", local_nodeID, 254);
        rx_cmd = 2'b10;
        age_pulse();
        chk("fol", state, S_FOL);
        chk("fol_id", local_nodeID, 4);
        chk("fol_pulse", txop_repick, 1);
        tick();
        chk("fol_pulse_end", txop_repick, 0);
        set_claim(4); upd = 1'b1;
        tick();
        upd = 1'b0;
        chk("refol_id", local_nodeID, 5);
        chk("refol_pulse", txop_repick, 1);
        tick();
        chk("refol_end", txop_repick, 0);

        plca_en = 1'b0;
        tick();
        chk("dis_state", state, S_DIS);
        chk("dis_aging", dplca_aging, 0);
        chk("dis_id_hold", local_nodeID, 5);
        plca_en = 1'b1; plca_status = 1'b0; claim = '0;
        for (int i = 0; i < 6; i++) tick();
        tx_cmd = 2'b00;
        tick();
        chk("ltx", state, S_LTX);
        tx_cmd = 2'b10; rx_cmd = 2'b00;
        tick();
        chk("lrx", state, S_LRX);
        rx_cmd = 2'b01;
        tick();
        chk("lrx_back", state, S_CRD);
        tx_cmd = 2'b00;
        tick();
        chk("ltx2", state, S_LTX);
        tx_cmd = 2'b10; rx_cmd = 2'b10;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        rx_cmd = 2'b00; tx_cmd = 2'b00;
        tick();
        chk("bcn_both", state, S_LRN);
        rx_cmd = 2'b10; tx_cmd = 2'b10;

        for (int n = 0; n < 4000; n++) begin
            dplca_en = $urandom_range(99) >= 2;
            plca_en = $urandom_range(99) >= 2;
            if ($urandom_range(99) < 10) plca_status = ~plca_status;
            if ($urandom_range(99) < 5) cra = ~cra;
            rx_cmd = $urandom_range(99) < 12 ? 2'b00 : 2'($urandom_range(1, 3));
            tx_cmd = $urandom_range(99) < 15 ? 2'b00 : 2'($urandom_range(1, 3));
            upd = $urandom_range(99) < 30;
            new_age = $urandom_range(99) < 40;
            tid = $urandom_range(3) == 0 ? 8'd0 : 8'($urandom_range(255));
            tcnt = 8'($urandom_range(255));
            if ($urandom_range(99) < 20) begin
                claim = '0;
                for (int i = 1; i < 24; i++) if ($urandom_range(99) < 35) claim[2*i +: 2] = 2'($urandom_range(1, 3));
                if ($urandom_range(9) == 0) claim[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(19) == 0) claim[2*254 +: 2] = 2'b10;
            end
            tick();
            if ($urandom_range(199) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
